// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
//   Front-end control stage for snake_top. It synchronises and debounces the
//   five raw push-buttons and turns presses into one-cycle direction pulses.
//   It also runs the START/PLAY/DIE game state machine.
//
// Parameters
//   DB_CNT    consecutive cycles a synchronised button must disagree with its
//             stable value before the change is accepted (>= 2)
//   DIE_HOLD  cycles spent in DIE before returning to START (>= 1)
//
// Ports
//   clk                          system clock (same clock as snake_top)
//   clr                          asynchronous active-low reset
//   btn_u/d/l/r/c                raw active-high buttons, asynchronous to clk
//   hit_wall, hit_body           collision flags from snake_top (clk domain)
//   U, D, L, R                   registered one-cycle direction pulses
//   s_start, s_play, s_die       registered one-hot game state
module snake_game_ctrl #(
  parameter int DB_CNT   = 1_000_000,
  parameter int DIE_HOLD = 300_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_u,
  input  logic btn_d,
  input  logic btn_l,
  input  logic btn_r,
  input  logic btn_c,
  input  logic hit_wall,
  input  logic hit_body,
  output logic U,
  output logic D,
  output logic L,
  output logic R,
  output logic s_start,
  output logic s_play,
  output logic s_die
);

  localparam int CW = $clog2(DB_CNT + 1);
  localparam int TW = $clog2(DIE_HOLD + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CNT - 1);
  localparam logic [TW-1:0] DIE_LAST = TW'(DIE_HOLD - 1);

  typedef enum logic [1:0] {ST_START, ST_PLAY, ST_DIE} state_t;

  // Heading encoding chosen so that the opposite direction is heading ^ 1.
  localparam logic [1:0] HD_UP    = 2'd0;
  localparam logic [1:0] HD_DOWN  = 2'd1;
  localparam logic [1:0] HD_LEFT  = 2'd2;
  localparam logic [1:0] HD_RIGHT = 2'd3;

  // Button vector index: 0=u 1=d 2=l 3=r 4=c
  logic [4:0] btn_raw;
  logic [4:0] press;
  logic [1:0] settle_reg;

  assign btn_raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

  // The synchronisers come out of reset holding 0, which is not a real
  // observation of the pin. settle_reg[1] marks the point where sync2 first
  // reflects the actual button level.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      settle_reg <= 2'b00;
    end else begin
      settle_reg <= {settle_reg[0], 1'b1};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_reg;
      logic          stable_d_reg;
      logic          armed_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          stable_reg   <= 1'b0;
          stable_d_reg <= 1'b0;
          armed_reg    <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= btn_raw[gi];
          sync2_reg    <= sync1_reg;
          stable_d_reg <= stable_reg;
          // The count reaches DB_CNT on the edge that sees DB_LAST plus one
          // more mismatch; that same edge commits the new stable value.
          if (sync2_reg != stable_reg) begin
            if (cnt_reg == DB_LAST) begin
              stable_reg <= sync2_reg;
              cnt_reg    <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
          // A button held through reset must be seen released before its
          // next rising edge counts as a press.
          if (settle_reg[1] && !sync2_reg && !stable_reg) begin
            armed_reg <= 1'b1;
          end
        end
      end

      assign press[gi] = stable_reg & ~stable_d_reg & armed_reg;
    end
  endgenerate

  state_t        state_reg;
  logic [1:0]    heading_reg;
  logic [TW-1:0] die_cnt_reg;
  logic          press_c_reg;
  logic          hit;
  logic          dir_valid;
  logic          dir_emit;
  logic [1:0]    dir_sel;

  assign hit = hit_wall | hit_body;

  // Priority U > D > L > R; a reversal of the current heading is dropped.
  always_comb begin
    dir_valid = |press[3:0];
    dir_sel   = HD_RIGHT;
    if (press[0]) begin
      dir_sel = HD_UP;
    end else if (press[1]) begin
      dir_sel = HD_DOWN;
    end else if (press[2]) begin
      dir_sel = HD_LEFT;
    end
    dir_emit = dir_valid && (dir_sel != (heading_reg ^ 2'b01));
  end

  // The centre button goes through one more register so that the state
  // change lands the cycle after its press pulse. Direction pulses are
  // loaded on the same edge that samples hit, so a hit wins over a press.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg   <= ST_START;
      heading_reg <= HD_RIGHT;
      die_cnt_reg <= '0;
      press_c_reg <= 1'b0;
      s_start     <= 1'b1;
      s_play      <= 1'b0;
      s_die       <= 1'b0;
      U           <= 1'b0;
      D           <= 1'b0;
      L           <= 1'b0;
      R           <= 1'b0;
    end else begin
      press_c_reg <= press[4];
      U           <= 1'b0;
      D           <= 1'b0;
      L           <= 1'b0;
      R           <= 1'b0;
      case (state_reg)
        ST_START: begin
          if (press_c_reg) begin
            state_reg   <= ST_PLAY;
            heading_reg <= HD_RIGHT;
            s_start     <= 1'b0;
            s_play      <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (hit) begin
            state_reg   <= ST_DIE;
            die_cnt_reg <= '0;
            s_play      <= 1'b0;
            s_die       <= 1'b1;
          end else if (dir_emit) begin
            heading_reg <= dir_sel;
            U           <= (dir_sel == HD_UP);
            D           <= (dir_sel == HD_DOWN);
            L           <= (dir_sel == HD_LEFT);
            R           <= (dir_sel == HD_RIGHT);
          end
        end
        ST_DIE: begin
          if (die_cnt_reg == DIE_LAST) begin
            state_reg   <= ST_START;
            die_cnt_reg <= '0;
            s_die       <= 1'b0;
            s_start     <= 1'b1;
          end else begin
            die_cnt_reg <= die_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_START;
          s_start   <= 1'b1;
          s_play    <= 1'b0;
          s_die     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Front-end control stage for the snake game, placed directly upstream of `snake_top`. It synchronises and debounces the five raw push-buttons and turns presses into one-cycle direction pulses. It runs the START/PLAY/DIE game state machine that drives `s_start`/`s_play`/`s_die`. It consumes `hit_wall`/`hit_body` coming back from `snake_top` to end a game.

## Interface
Parameters:
- `DB_CNT`, default 1_000_000: consecutive stable cycles before a button change is accepted (10 ms at 100 MHz); ≥ 2.
- `DIE_HOLD`, default 300_000_000: cycles spent in DIE before returning to START (3 s at 100 MHz); ≥ 1.

Ports:
- `clk`  in  1  system clock; the block's only clock, the same `clk` that feeds `snake_top`.
- `clr`  in  1  reset, asynchronous, active-low.
- `btn_u`, `btn_d`, `btn_l`, `btn_r`, `btn_c`  in  1 each  raw buttons, active-high, asynchronous to `clk`.
- `hit_wall`, `hit_body`  in  1 each  collision flags from `snake_top`, synchronous to `clk`.
- `U`, `D`, `L`, `R`  out  1 each  one-cycle direction pulses, connected to `snake_top`.
- `s_start`, `s_play`, `s_die`  out  1 each  one-hot game state.

## Operation
- **Input conditioning (per button):**
  - 2-FF synchroniser.
  - Debounce counter compares the synchronised value with the registered stable value. On a mismatch it counts; on a match it clears to 0.
  - When the count reaches `DB_CNT`, the stable value takes the synchronised value and the counter clears.
  - Counter width is `$clog2(DB_CNT+1)`. The counter never wraps.
- **Press detect:** a press is a 0→1 transition of the stable value, giving a one-cycle internal pulse. A 1→0 transition produces nothing.
- **FSM states:** START, PLAY, DIE. Exactly one of `s_start`/`s_play`/`s_die` is high at all times.
  - START → PLAY on a `btn_c` press.
  - PLAY → DIE when `hit_wall | hit_body` is high on a clock edge.
  - DIE → START when the hold timer reaches `DIE_HOLD`-1. The timer clears on entry to DIE and counts every cycle in DIE.
  - A `btn_c` press in PLAY or DIE is ignored.
  - A hit in START or DIE is ignored.
- **Heading register (2 bits):** set to RIGHT on every START→PLAY transition. It is updated only by direction pulses that are emitted.
- **Direction output:**
  - Active only in PLAY. In START and DIE, U/D/L/R are 0 and presses are discarded.
  - Simultaneous presses: priority U > D > L > R. At most one pulse per cycle; lower-priority presses in that cycle are dropped.
  - A press opposite the current heading (U vs D, L vs R) is suppressed: no pulse and no heading change.
  - A press equal to the current heading is emitted.
- **Hit vs. press in the same PLAY cycle:** the hit wins. The FSM goes to DIE and no direction pulse is emitted.
- **Reset:**
  - Values while `clr` is low: FSM = START (`s_start`=1, `s_play`=0, `s_die`=0); U/D/L/R=0; heading=RIGHT; all synchronisers, stable values, debounce counters and the DIE timer are 0.
  - Asserting `clr` mid-game takes effect immediately, asynchronously.
  - Buttons held through reset release must first read 0 as stable before they can produce a press.

## Timing
- **Button latency:** raw edge at cycle 0 → synchronised at cycle 2. The stable value updates at cycle 2+`DB_CNT` if the input is held, and the registered press/direction pulse is high during cycle 3+`DB_CNT`.
- **Bounce:** any glitch shorter than `DB_CNT` cycles after synchronisation is rejected.
- **Registered outputs:** all outputs are registered; no combinational path from any input to any output.
- **State outputs:** `s_*` change one cycle after the triggering press pulse or hit sample.
- **DIE duration:** exactly `DIE_HOLD` cycles of `s_die`=1, then `s_start`=1.
- **Pulse width:** direction pulses are exactly 1 cycle wide. A held button yields one pulse per press.

## Test plan
All scenarios use `DB_CNT`=4, `DIE_HOLD`=10.

1. **Reset and start:** release `clr`; raise `btn_c` at cycle 0 and hold it. Required: `s_start`=1 through cycle 7, `s_play`=1 from cycle 8; U/D/L/R stay 0.
2. **Bounce rejection:** in PLAY, toggle `btn_u` with high pulses of 3 cycles and gaps of 2 cycles. Required: no U pulse. Then hold `btn_u` high. Required: exactly one 1-cycle U pulse, 7 cycles after the final rising edge.
3. **Reversal and priority:** from fresh PLAY (heading RIGHT), press L → no pulse. Press U and R in the same cycle → single U pulse only. Then press D → no pulse. Then press L → L pulse.
4. **Game over cycle:** in PLAY, assert `hit_body` for 1 cycle together with a `btn_r` press pulse. Required: no R pulse; `s_die`=1 for exactly 10 cycles, then `s_start`=1. A `btn_c` press during DIE does not shorten or extend DIE.
5. **Idle-state masking:** in START, press U/D/L/R and assert `hit_wall`. Required: outputs stay 0 and `s_start` stays 1.
6. **Async reset mid-game:** pull `clr` low in PLAY between clock edges. Required: `s_start`=1 and U/D/L/R=0 immediately, without a clock edge. After release, a button that was held through reset produces no pulse until it is released and pressed again.
